// File: rtl/mdu_e.sv
// mdu_e: E-stage multiply/divide unit holding HI/LO with a counted busy window
module mdu_e #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        busy,
  output logic [31:0] HIE,
  output logic [31:0] LOE
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic [63:0] res, res_nx, prod, ae, be;
  logic signed [32:0] ad, bd;
  logic res_ok, ok_nx, accept, done, sx, mt_ok;
  always_comb begin
    accept = state == IDLE && start && !op[2];
    mt_ok = state == IDLE && start;
    done = state == RUN && cnt == 32'd1;
    state_nx = accept ? RUN : done ? IDLE : state;
    sx = !op[0];
    ae = {{32{sx & A[31]}}, A};
    be = {{32{sx & B[31]}}, B};
    prod = ae * be;
    ad = {sx & A[31], A};
    bd = B == 32'd0 ? 33'sd1 : {sx & B[31], B};
    res_nx = op[1] ? {32'(ad % bd), 32'(ad / bd)} : prod;
    ok_nx = !op[1] || B != 32'd0;
  end
  assign busy = state == RUN;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      res <= '0;
      res_ok <= 1'b0;
      HIE <= '0;
      LOE <= '0;
    end else begin
      state <= state_nx;
      cnt <= accept ? 32'(op[1] ? DIV_CYCLES : MULT_CYCLES) : state == RUN ? cnt - 32'd1 : cnt;
      res <= accept ? res_nx : res;
      res_ok <= accept ? ok_nx : done ? 1'b0 : res_ok;
      HIE <= mt_ok && op == 3'd4 ? A : done && res_ok ? res[63:32] : HIE;
      LOE <= mt_ok && op == 3'd5 ? A : done && res_ok ? res[31:0] : LOE;
    end
  end
endmodule
